// File: rtl/router_pkt_gen.sv
// Packet source for the router input port: emits bursts of framed packets
// (header {len, addr}, payload bytes, parity byte) and honours busy.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for start; outputs idle
// S_HEADER  | header {len, addr} on data_in, pkt_valid=1
// S_PAYLOAD | payload byte on data_in, pkt_valid=1
// S_PARITY  | parity byte (inverted when injecting errors), pkt_valid=0
// S_GAP     | inter-packet idle, GAP_CYCLES cycles, ignores busy
module router_pkt_gen #(
  parameter int              DATA_W     = 8,
  parameter int              ADDR_W     = 2,
  parameter int              NUM_CH     = 3,
  parameter int              GAP_CYCLES = 2,
  parameter logic [DATA_W-1:0] LFSR_SEED = 8'hA5,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int              CNT_W      = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [DATA_W-ADDR_W-1:0] cfg_len,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [7:0]               cfg_npkts,
  input  logic [1:0]               cfg_mode,
  input  logic                     cfg_rotate,
  input  logic                     inject_err,
  input  logic                     busy,
  output logic [DATA_W-1:0]        data_in,
  output logic                     pkt_valid,
  output logic                     active,
  output logic                     done,
  output logic [CNT_W-1:0]         pkt_cnt
);

  localparam int LEN_W = DATA_W - ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          mode_q, mode_d;
  logic                rotate_q, rotate_d;
  logic                err_q, err_d;
  logic [7:0]          rem_q, rem_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         gap_q, gap_d;
  logic [DATA_W-1:0]   inc_q, inc_d;
  logic [DATA_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   parity_q, parity_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [ADDR_W:0]     addr_inc;
  logic [DATA_W-1:0]   pl_cur;

  function automatic logic [DATA_W-1:0] pl_byte(input logic [1:0] m,
                                                input logic [DATA_W-1:0] inc,
                                                input logic [DATA_W-1:0] lfsr);
    case (m)
      2'b01:   pl_byte = lfsr;
      2'b10:   pl_byte = '1;
      default: pl_byte = inc;
    endcase
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    rotate_d  = rotate_q;
    err_d     = err_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    inc_d     = inc_q;
    lfsr_d    = lfsr_q;
    parity_d  = parity_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    addr_inc  = {1'b0, addr_q} + (ADDR_W+1)'(1);
    pl_cur    = pl_byte(mode_q, inc_q, lfsr_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = cfg_len;
          addr_d   = cfg_addr;
          mode_d   = cfg_mode;
          rotate_d = cfg_rotate;
          err_d    = inject_err;
          inc_d    = '0;
          lfsr_d   = LFSR_SEED;
          if (cfg_npkts != 8'd0) begin
            rem_d    = cfg_npkts;
            active_d = 1'b1;
            state_d  = S_HEADER;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          parity_d = {len_q, addr_q};
          cnt_d    = len_q;
          state_d  = (len_q == '0) ? S_PARITY : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          parity_d = parity_q ^ pl_cur;
          inc_d    = inc_q + DATA_W'(1);
          lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          if (rotate_q) addr_d = ADDR_W'(int'(addr_inc) % NUM_CH);
          if (rem_q == 8'd1) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            active_d = 1'b0;
          end else begin
            rem_d = rem_q - 8'd1;
            if (GAP_CYCLES == 0) begin
              state_d = S_HEADER;
            end else begin
              gap_d   = 16'(GAP_CYCLES - 1);
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == 16'd0) state_d = S_HEADER;
        else                gap_d   = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are a function of the state being entered, so they are valid
    // in the same cycle the state register shows that state.
    data_d  = '0;
    valid_d = 1'b0;
    case (state_d)
      S_HEADER: begin
        data_d  = {len_d, addr_d};
        valid_d = 1'b1;
      end
      S_PAYLOAD: begin
        data_d  = pl_byte(mode_d, inc_d, lfsr_d);
        valid_d = 1'b1;
      end
      S_PARITY: data_d = err_d ? ~parity_d : parity_d;
      default:  data_d = '0;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      mode_q    <= '0;
      rotate_q  <= 1'b0;
      err_q     <= 1'b0;
      rem_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      inc_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      parity_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      rotate_q  <= rotate_d;
      err_q     <= err_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      inc_q     <= inc_d;
      lfsr_q    <= lfsr_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      done_q    <= done_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign data_in   = data_q;
  assign pkt_valid = valid_q;
  assign active    = active_q;
  assign done      = done_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: a reference model pushes the
// expected byte stream per burst; a monitor pops and compares each accepted
// byte. Scenario tasks check timing, back-pressure, gaps and reset.
module tb_router_pkt_gen;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [5:0] cfg_len;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_npkts;
  logic [1:0] cfg_mode;
  logic       cfg_rotate;
  logic       inject_err;
  logic       busy;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       active;
  logic       done;
  logic [15:0] pkt_cnt;

  logic [8:0] exp_q[$];
  int         gap_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         in_pkt  = 1'b0;
  int         idle_run = 0;

  router_pkt_gen dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_addr   (cfg_addr),
    .cfg_npkts  (cfg_npkts),
    .cfg_mode   (cfg_mode),
    .cfg_rotate (cfg_rotate),
    .inject_err (inject_err),
    .busy       (busy),
    .data_in    (data_in),
    .pkt_valid  (pkt_valid),
    .active     (active),
    .done       (done),
    .pkt_cnt    (pkt_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: expected {pkt_valid, data} for every byte of a burst
  function automatic void push_burst(input logic [5:0] len, input logic [1:0] addr,
                                     input logic [1:0] mode, input logic [7:0] np,
                                     input logic rot, input logic err);
    logic [7:0] inc, lf, par, b, hdr;
    logic [1:0] a;
    inc = 8'h00;
    lf  = 8'hA5;
    a   = addr;
    for (int p = 0; p < int'(np); p++) begin
      hdr = {len, a};
      exp_q.push_back({1'b1, hdr});
      par = hdr;
      for (int i = 0; i < int'(len); i++) begin
        case (mode)
          2'b01:   b = lf;
          2'b10:   b = 8'hFF;
          default: b = inc;
        endcase
        exp_q.push_back({1'b1, b});
        par = par ^ b;
        inc = inc + 8'd1;
        lf  = lf[0] ? ((lf >> 1) ^ 8'hB8) : (lf >> 1);
      end
      exp_q.push_back({1'b0, err ? ~par : par});
      if (rot) a = 2'((int'(a) + 1) % 3);
    end
  endfunction

  // Scoreboard monitor: samples on the falling edge, compares accepted bytes
  task automatic monitor();
    logic [8:0] e;
    bit take;
    forever begin
      @(negedge clock);
      take = 1'b0;
      if (!resetn) begin
        in_pkt   = 1'b0;
        idle_run = 0;
      end else if (pkt_valid) begin
        if (!in_pkt) begin
          gap_q.push_back(idle_run);
          idle_run = 0;
          in_pkt   = 1'b1;
        end
        take = !busy;
      end else if (in_pkt) begin
        take = !busy;
        if (take) begin
          in_pkt   = 1'b0;
          idle_run = 0;
        end
      end else if (active) begin
        idle_run++;
      end
      if (take) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL byte_unexpected: got valid=%b data=%h, required no byte", pkt_valid, data_in);
        end else begin
          e = exp_q.pop_front();
          if ({pkt_valid, data_in} !== e) begin
            n_fail++;
            $display("FAIL byte: got valid=%b data=%h, required valid=%b data=%h",
                     pkt_valid, data_in, e[8], e[7:0]);
          end
        end
      end
    end
  endtask

  // Drive a burst config, pulse start, then scramble cfg to prove capture
  task automatic launch(input logic [5:0] len, input logic [1:0] addr, input logic [1:0] mode,
                        input logic [7:0] np, input logic rot, input logic err);
    push_burst(len, addr, mode, np, rot, err);
    @(posedge clock); #1;
    cfg_len = len; cfg_addr = addr; cfg_mode = mode; cfg_npkts = np;
    cfg_rotate = rot; inject_err = err; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cfg_len = ~len; cfg_addr = ~addr; cfg_mode = 2'b10 ^ mode; cfg_npkts = 8'd9;
    cfg_rotate = ~rot; inject_err = ~err;
  endtask

  task automatic run_to_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (!done && cycles < budget);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; busy = 1'b0;
    cfg_len = '0; cfg_addr = '0; cfg_npkts = '0; cfg_mode = '0;
    cfg_rotate = 1'b0; inject_err = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if ({data_in, pkt_valid, active, done, pkt_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b active=%b done=%b cnt=%0d, required all 0",
               data_in, pkt_valid, active, done, pkt_cnt);
    end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    int cyc;
    launch(6'd14, 2'd1, 2'b00, 8'd1, 1'b0, 1'b0);
    n_tests++;
    if ({active, pkt_valid, data_in} !== 10'h3_39) begin
      n_fail++;
      $display("FAIL first_header: got active=%b valid=%b data=%h, required 1 1 39", active, pkt_valid, data_in);
    end
    run_to_done(200, cyc);
    n_tests++;
    if (cyc !== 16) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles, required 16", cyc);
    end
    n_tests++;
    if (pkt_cnt !== 16'd1 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cnt: got cnt=%0d active=%b, required 1 0", pkt_cnt, active);
    end
    @(posedge clock); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b a cycle later, required 0", done);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain: got %0d bytes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_busy();
    int cyc, hold, held, held_bad;
    bit did;
    launch(6'd14, 2'd1, 2'b00, 8'd1, 1'b0, 1'b0);
    cyc = 0; hold = 0; held = 0; held_bad = 0; did = 1'b0;
    do begin
      @(posedge clock); #1;
      cyc++;
      if (hold > 0) begin
        held++;
        if ({pkt_valid, data_in} !== 9'h105) held_bad++;
        hold--;
        if (hold == 0) busy = 1'b0;
      end else if (!did && pkt_valid && data_in == 8'h05) begin
        busy = 1'b1;
        hold = 3;
        did  = 1'b1;
      end
    end while (!done && cyc < 200);
    busy = 1'b0;
    n_tests++;
    if (held !== 3 || held_bad !== 0) begin
      n_fail++;
      $display("FAIL busy_hold: got %0d held samples with %0d wrong, required 3 and 0", held, held_bad);
    end
    n_tests++;
    if (cyc !== 19) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d cycles, required 19", cyc);
    end
    n_tests++;
    if (pkt_cnt !== 16'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL busy_cnt: got cnt=%0d left=%0d, required 2 0", pkt_cnt, exp_q.size());
    end
  endtask

  task automatic test_zero_len_err();
    int cyc;
    launch(6'd0, 2'd2, 2'b00, 8'd1, 1'b0, 1'b1);
    run_to_done(50, cyc);
    n_tests++;
    if (cyc !== 2 || pkt_cnt !== 16'd3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len: got cycles=%0d cnt=%0d left=%0d, required 2 3 0", cyc, pkt_cnt, exp_q.size());
    end
  endtask

  task automatic test_rotate();
    int cyc;
    gap_q.delete();
    launch(6'd2, 2'd0, 2'b11, 8'd4, 1'b1, 1'b0);
    run_to_done(200, cyc);
    n_tests++;
    if (cyc !== 22 || pkt_cnt !== 16'd7 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rotate_burst: got cycles=%0d cnt=%0d left=%0d, required 22 7 0", cyc, pkt_cnt, exp_q.size());
    end
    n_tests++;
    if (gap_q.size() != 4) begin
      n_fail++;
      $display("FAIL gap_count: got %0d headers, required 4", gap_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_tests++;
        if (gap_q[i] !== 2) begin
          n_fail++;
          $display("FAIL gap_len: got %0d idle cycles before packet %0d, required 2", gap_q[i], i);
        end
      end
    end
  endtask

  task automatic test_lfsr();
    int cyc;
    launch(6'd3, 2'd3, 2'b01, 8'd1, 1'b0, 1'b0);
    run_to_done(50, cyc);
    n_tests++;
    if (cyc !== 5 || pkt_cnt !== 16'd8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lfsr_burst: got cycles=%0d cnt=%0d left=%0d, required 5 8 0", cyc, pkt_cnt, exp_q.size());
    end
  endtask

  task automatic test_ones_oob_addr();
    int cyc;
    launch(6'd2, 2'd3, 2'b10, 8'd2, 1'b1, 1'b0);
    run_to_done(100, cyc);
    n_tests++;
    if (cyc !== 10 || pkt_cnt !== 16'd10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ones_burst: got cycles=%0d cnt=%0d left=%0d, required 10 10 0", cyc, pkt_cnt, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    launch(6'd14, 2'd1, 2'b00, 8'd1, 1'b0, 1'b0);
    guard = 0;
    while (!(pkt_valid && data_in == 8'h03) && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    n_tests++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL mid_reset_wait: got no payload byte 3 in %0d cycles, required it", guard);
    end
    resetn = 1'b0; start = 1'b1; cfg_npkts = 8'd1;
    @(posedge clock); #1;
    resetn = 1'b1; start = 1'b0;
    n_tests++;
    if ({data_in, pkt_valid, active, done, pkt_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got data=%h valid=%b active=%b done=%b cnt=%0d, required all 0",
               data_in, pkt_valid, active, done, pkt_cnt);
    end
    exp_q.delete();
    repeat (3) begin
      @(posedge clock); #1;
      n_tests++;
      if (active !== 1'b0 || done !== 1'b0 || pkt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL start_in_reset: got active=%b done=%b valid=%b, required 0 0 0", active, done, pkt_valid);
      end
    end
    cfg_npkts = 8'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n_tests++;
    if ({done, active, pkt_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL npkts0_done: got done=%b active=%b valid=%b, required 1 0 0", done, active, pkt_valid);
    end
    @(posedge clock); #1;
    n_tests++;
    if ({done, active, pkt_valid} !== 3'b000 || pkt_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL npkts0_after: got done=%b active=%b valid=%b cnt=%0d, required 0 0 0 0",
               done, active, pkt_valid, pkt_cnt);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_busy();
    test_zero_len_err();
    test_rotate();
    test_lfsr();
    test_ones_oob_addr();
    test_mid_reset();
    repeat (3) @(posedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d bytes pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

endmodule
